// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester owns the transaction in flight
//   MAX_D_STREAK_DEF : default number of back-to-back data grants while fetch waits
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int unsigned MAX_D_STREAK_DEF = 4;

endpackage

// File: rtl/arb_priority.sv
// Winner select between fetch and data plus the data-streak counter.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   arb_en            : arbitration allowed this cycle (FSM idle)
//   if_req, d_req     : pending requests
//   grant_if, grant_d : one-hot grant, only while arb_en
module arb_priority
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic grant_if,
    output logic grant_d
);

    localparam int unsigned SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak;
    logic          d_wins;

    // Data has priority until it has starved a waiting fetch MAX_D_STREAK times.
    assign d_wins   = d_req & (~if_req | (streak < STREAK_MAX));
    assign grant_d  = arb_en & d_wins;
    assign grant_if = arb_en & if_req & ~d_wins;

    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (grant_d) begin
            if (!if_req) begin
                streak <= '0;
            end else if (streak < STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end else if (grant_if) begin
            streak <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and the data stage.
// One transaction at a time: IDLE (arbitrate/capture) -> REQ (hold m_req until m_gnt)
// -> WAIT (until m_rvalid) -> RESP (one-cycle valid to the owner).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr/if_rdata/if_valid/if_stall : fetch side (32-bit instruction word)
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_valid/mem_stall : data side
//   flush                           : cancels delivery of an owned fetch
//   m_req/m_we/m_addr/m_wdata/m_gnt/m_rvalid/m_rdata : memory port
// DATA_W is expected to be 64; the instruction word is picked from one half.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_stall,
    input  logic              flush,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    state_t            state;
    owner_t            owner;
    logic              drop;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              hi_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant_if;
    logic              grant_d;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[1:0], d_addr[2:0]};

    arb_priority #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_arb_priority (
        .clk     (clk),
        .reset   (reset),
        .arb_en  (state == IDLE),
        .if_req  (if_req),
        .d_req   (d_req),
        .grant_if(grant_if),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= OWN_IF;
            drop    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            hi_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_d || grant_if) begin
                        state   <= REQ;
                        owner   <= grant_d ? OWN_D : OWN_IF;
                        drop    <= 1'b0;
                        addr_q  <= grant_d ? {d_addr[ADDR_W-1:3], 3'b000}
                                           : {if_addr[ADDR_W-1:3], 3'b000};
                        wdata_q <= grant_d ? d_wdata : '0;
                        we_q    <= grant_d & d_we;
                        hi_q    <= ~grant_d & if_addr[2];
                    end
                end
                REQ: begin
                    // The handshake cannot be withdrawn, so a flush only marks the reply.
                    if (owner == OWN_IF && flush) drop <= 1'b1;
                    if (m_gnt) begin
                        if (m_rvalid) begin
                            state   <= RESP;
                            rdata_q <= m_rdata;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (owner == OWN_IF && flush) drop <= 1'b1;
                    if (m_rvalid) begin
                        state   <= RESP;
                        rdata_q <= m_rdata;
                    end
                end
                RESP: begin
                    drop  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign m_req   = (state == REQ);
    assign m_we    = we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

    // A flush landing in RESP itself must still suppress the pulse.
    assign if_valid = (state == RESP) & (owner == OWN_IF) & ~drop & ~flush;
    assign d_valid  = (state == RESP) & (owner == OWN_D);
    assign if_rdata = hi_q ? rdata_q[63:32] : rdata_q[31:0];
    assign d_rdata  = rdata_q;

    assign if_stall  = if_req & ~if_valid;
    assign mem_stall = d_req & ~d_valid;

endmodule
